dm_access_ctrl: RTL and testbench

- Multi-cycle sequencer between the execute unit and the data memory bus.
- Accepts one load/store request per transaction and checks alignment.
- Drives a valid/ready address phase, then waits for the memory response.
- Returns sign/zero-extended load data or a store acknowledge to writeback, with a timeout watchdog.
- The control unit stalls the pipeline while `o_busy` is high.

---
 rtl/dm_access_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer: one load/store per transaction, alignment
// checking, valid/ready address phase, response wait with a timeout watchdog.
module dm_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_eu_dm_req_valid,
  output logic              o_eu_dm_req_ready,
  input  logic              i_eu_dm_wvalid,
  input  logic [2:0]        i_eu_dm_op_data,
  input  logic [ADDR_W-1:0] i_eu_dm_addr,
  input  logic [31:0]       i_eu_dm_wdata,
  output logic              o_mem_avalid,
  input  logic              i_mem_aready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_wstrb,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_wb_dm_rsp_valid,
  output logic              o_wb_dm_rsp_err,
  output logic [31:0]       o_wb_dm_rdata,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR,
    S_ADDR,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic               req_illegal;
  logic [3:0]         req_wstrb;
  logic [31:0]        req_wdata;
  logic [31:0]        rd_shifted;
  logic [31:0]        load_data;
  logic               timed_out;

  // Illegal: reserved funct3, unsigned store, misaligned halfword/word.
  assign req_illegal = (i_eu_dm_op_data == 3'b011)
                     || (i_eu_dm_op_data[2:1] == 2'b11)
                     || (i_eu_dm_wvalid && i_eu_dm_op_data[2])
                     || ((i_eu_dm_op_data[1:0] == 2'b01) && i_eu_dm_addr[0])
                     || ((i_eu_dm_op_data == 3'b010) && (i_eu_dm_addr[1:0] != 2'b00));

  always_comb begin
    req_wstrb = 4'b0000;
    req_wdata = 32'h0;
    if (i_eu_dm_wvalid) begin
      unique case (i_eu_dm_op_data[1:0])
        2'b00: begin
          req_wstrb = 4'b0001 << i_eu_dm_addr[1:0];
          req_wdata = {4{i_eu_dm_wdata[7:0]}};
        end
        2'b01: begin
          req_wstrb = 4'b0011 << i_eu_dm_addr[1:0];
          req_wdata = {2{i_eu_dm_wdata[15:0]}};
        end
        default: begin
          req_wstrb = 4'b1111;
          req_wdata = i_eu_dm_wdata;
        end
      endcase
    end
  end

  assign rd_shifted = i_mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    unique case (op_q)
      3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b100:  load_data = {24'h0, rd_shifted[7:0]};
      3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b101:  load_data = {16'h0, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

  // cnt_q counts completed ADDR/RESP cycles, so the TIMEOUT-th cycle sees TIMEOUT-1.
  assign timed_out = (cnt_q >= CNT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        if (i_eu_dm_req_valid) begin
          if (req_illegal) begin
            state_d     = S_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_ADDR;
            cnt_d   = '0;
            op_d    = i_eu_dm_op_data;
            we_d    = i_eu_dm_wvalid;
            addr_d  = i_eu_dm_addr;
            wstrb_d = req_wstrb;
            wdata_d = req_wdata;
          end
        end
      end
      S_ERR: state_d = S_IDLE;
      S_ADDR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_aready) begin
          state_d = S_RESP;
        end else if (timed_out) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_rvalid) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : load_data;
        end else if (timed_out) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 3'b000;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign o_eu_dm_req_ready = (state_q == S_IDLE);
  assign o_busy            = (state_q != S_IDLE);
  assign o_mem_avalid      = (state_q == S_ADDR);
  assign o_mem_addr        = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_we          = we_q;
  assign o_mem_wstrb       = wstrb_q;
  assign o_mem_wdata       = wdata_q;
  assign o_wb_dm_rsp_valid = rsp_valid_q;
  assign o_wb_dm_rsp_err   = rsp_err_q;
  assign o_wb_dm_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with TIMEOUT=8; inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        wvalid;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        avalid;
  logic        aready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_eu_dm_req_valid (req_valid),
    .o_eu_dm_req_ready (req_ready),
    .i_eu_dm_wvalid    (wvalid),
    .i_eu_dm_op_data   (op),
    .i_eu_dm_addr      (addr),
    .i_eu_dm_wdata     (wdata),
    .o_mem_avalid      (avalid),
    .i_mem_aready      (aready),
    .o_mem_addr        (mem_addr),
    .o_mem_we          (mem_we),
    .o_mem_wstrb       (mem_wstrb),
    .o_mem_wdata       (mem_wdata),
    .i_mem_rvalid      (rvalid),
    .i_mem_rdata       (rdata),
    .o_wb_dm_rsp_valid (rsp_valid),
    .o_wb_dm_rsp_err   (rsp_err),
    .o_wb_dm_rdata     (rsp_rdata),
    .o_busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; afterwards the DUT has taken it.
  task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    check("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    wvalid    = we;
    op        = f3;
    addr      = a;
    wdata     = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Address phase after a_wait stalled cycles, then rvalid after r_wait idle cycles.
  task automatic mem_phase(input int a_wait, input int r_wait, input logic [31:0] rd,
                           input logic [31:0] exp_addr, input logic exp_we,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    for (int i = 0; i < a_wait; i++) begin
      aready = 1'b0;
      check("avalid_stall", 32'(avalid), 32'd1);
      check("addr_stall", mem_addr, exp_addr);
      check("wstrb_stall", 32'(mem_wstrb), 32'(exp_strb));
      tick();
    end
    aready = 1'b1;
    check("avalid", 32'(avalid), 32'd1);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
    if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
    tick();
    aready = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      check("no_early_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    check("rsp_not_yet", 32'(rsp_valid), 32'd0);
    rvalid = 1'b1;
    rdata  = rd;
    tick();
    rvalid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic err, input logic [31:0] data);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
    check({tag, "_rdata"}, rsp_rdata, data);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic illegal_req(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] a);
    accept(we, f3, a, 32'h12345678);
    check({tag, "_avalid"}, 32'(avalid), 32'd0);
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"}, 32'(rsp_err), 32'd1);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
    tick();
    check({tag, "_busy0"}, 32'(busy), 32'd0);
    check({tag, "_avalid2"}, 32'(avalid), 32'd0);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; wvalid = 1'b0; op = 3'b000; addr = 32'h0;
    wdata = 32'h0; aready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_avalid", 32'(avalid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // LW with immediate handshakes: response exactly 3 cycles after accept.
    accept(1'b0, 3'b010, 32'h100, 32'h0);
    mem_phase(0, 0, 32'hDEADBEEF, 32'h100, 1'b0, 4'b0000, 32'h0);
    expect_rsp("lw", 1'b0, 32'hDEADBEEF);

    accept(1'b0, 3'b000, 32'h103, 32'h0);
    mem_phase(0, 0, 32'h80FF0000, 32'h100, 1'b0, 4'b0000, 32'h0);
    expect_rsp("lb", 1'b0, 32'hFFFFFF80);
    accept(1'b0, 3'b100, 32'h103, 32'h0);
    mem_phase(0, 0, 32'h80FF0000, 32'h100, 1'b0, 4'b0000, 32'h0);
    expect_rsp("lbu", 1'b0, 32'h00000080);
    accept(1'b0, 3'b001, 32'h102, 32'h0);
    mem_phase(0, 0, 32'h80FF0000, 32'h100, 1'b0, 4'b0000, 32'h0);
    expect_rsp("lh", 1'b0, 32'hFFFF80FF);
    accept(1'b0, 3'b101, 32'h102, 32'h0);
    mem_phase(0, 0, 32'h80FF0000, 32'h100, 1'b0, 4'b0000, 32'h0);
    expect_rsp("lhu", 1'b0, 32'h000080FF);

    accept(1'b1, 3'b000, 32'h201, 32'h12345678);
    mem_phase(0, 0, 32'hFFFFFFFF, 32'h200, 1'b1, 4'b0010, 32'h78787878);
    expect_rsp("sb", 1'b0, 32'h0);
    accept(1'b1, 3'b001, 32'h202, 32'h12345678);
    mem_phase(0, 1, 32'hFFFFFFFF, 32'h200, 1'b1, 4'b1100, 32'h56785678);
    expect_rsp("sh", 1'b0, 32'h0);
    accept(1'b1, 3'b010, 32'h200, 32'h12345678);
    mem_phase(0, 0, 32'hFFFFFFFF, 32'h200, 1'b1, 4'b1111, 32'h12345678);
    expect_rsp("sw", 1'b0, 32'h0);

    illegal_req("sw_mis", 1'b1, 3'b010, 32'h202);
    illegal_req("lh_mis", 1'b0, 3'b001, 32'h101);
    illegal_req("op011", 1'b0, 3'b011, 32'h100);
    illegal_req("sbu", 1'b1, 3'b100, 32'h100);

    // Address-phase backpressure for 3 cycles.
    accept(1'b1, 3'b000, 32'h303, 32'h000000A5);
    mem_phase(3, 0, 32'h0, 32'h300, 1'b1, 4'b1000, 32'hA5A5A5A5);
    expect_rsp("bp", 1'b0, 32'h0);

    // No rvalid: error after the 8th ADDR+RESP cycle.
    accept(1'b0, 3'b010, 32'h108, 32'h0);
    aready = 1'b1;
    tick();
    aready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("to_busy", 32'(busy), 32'd1);
      check("to_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    expect_rsp("to_resp", 1'b1, 32'h0);

    // aready never comes: avalid for 8 cycles, then dropped with an error.
    accept(1'b0, 3'b010, 32'h10C, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("toa_avalid", 32'(avalid), 32'd1);
      tick();
    end
    check("toa_avalid_drop", 32'(avalid), 32'd0);
    expect_rsp("to_addr", 1'b1, 32'h0);

    // rvalid on the 8th cycle beats the watchdog.
    accept(1'b0, 3'b010, 32'h110, 32'h0);
    mem_phase(0, 6, 32'h0BADF00D, 32'h110, 1'b0, 4'b0000, 32'h0);
    expect_rsp("to_edge", 1'b0, 32'h0BADF00D);

    // Back-to-back: accept a new request while rsp_valid is high.
    accept(1'b0, 3'b010, 32'h114, 32'h0);
    mem_phase(0, 0, 32'h11111111, 32'h114, 1'b0, 4'b0000, 32'h0);
    check("b2b_valid", 32'(rsp_valid), 32'd1);
    accept(1'b0, 3'b010, 32'h118, 32'h0);
    mem_phase(0, 0, 32'h22222222, 32'h118, 1'b0, 4'b0000, 32'h0);
    expect_rsp("b2b", 1'b0, 32'h22222222);

    // Asynchronous reset in RESP drops the outstanding response.
    accept(1'b1, 3'b010, 32'h11C, 32'h55555555);
    aready = 1'b1;
    tick();
    aready = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_wstrb", 32'(mem_wstrb), 32'd0);
    check("arst_wdata", mem_wdata, 32'h0);
    check("arst_addr", mem_addr, 32'h0);
    #2;
    rst = 1'b0;
    tick();
    rvalid = 1'b1;
    rdata  = 32'h99999999;
    tick();
    rvalid = 1'b0;
    check("late_rvalid", 32'(rsp_valid), 32'd0);
    tick();
    check("late_rvalid2", 32'(rsp_valid), 32'd0);
    accept(1'b0, 3'b010, 32'h120, 32'h0);
    mem_phase(0, 0, 32'h76543210, 32'h120, 1'b0, 4'b0000, 32'h0);
    expect_rsp("post_rst", 1'b0, 32'h76543210);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
